period_meter: RTL and testbench
===============================

// Module: period_meter
//
// PURPOSE
//  Measures the period of a slow asynchronous input (a divided clock, blink or
//  sensor pulse) in clk_50MHz cycles, from rising edge to rising edge.
//  Complements the clock divider: the divider produces slow ticks from the fast
//  clock, and this block recovers a slow signal's period against the fast clock.
//  Feeds display/check logic through a one-cycle valid strobe and a stall flag.
//
// PARAMETERS
//  CNT_W        32           width of the period counter and period output
//  TIMEOUT      150000000    cycles without a rising edge before stall (3 s); must be < 2**CNT_W
//  SYNC_STAGES  2            synchroniser depth for sig_in, >= 2
//
// PORTS
//  clk_50MHz     in   1      sole clock, 50 MHz
//  set           in   1      synchronous, active-high reset
//  sig_in        in   1      asynchronous input to measure
//  period        out  CNT_W  last measured period, in clk cycles
//  period_valid  out  1      one-cycle strobe when period updates
//  timeout       out  1      level: no rising edge for TIMEOUT cycles
//  edge_cnt      out  16     count of completed measurements, wraps at 2**16
//
// BEHAVIOUR
//  - Reset values: period=0, period_valid=0, timeout=0, edge_cnt=0, state=IDLE, cnt=0.
//  - Synchroniser flops reset to 0. The edge-history flop resets to 1, so an input
//    already high at reset release is not a rising edge.
//  - rise = sync_out & ~hist. It is asserted SYNC_STAGES+1 cycles after sig_in rises.
//  - States:
//    IDLE: wait for rise; on rise go to MEASURE with cnt=0. No valid strobe on this first edge.
//    MEASURE: cnt increments each cycle.
//      On rise: period<=cnt+1, period_valid<=1 for one cycle, edge_cnt++, cnt<=0, stay in MEASURE.
//      If cnt==TIMEOUT-1 and no rise: go to STALL, timeout<=1, cnt held. period is not updated.
//      If rise and the timeout condition occur in the same cycle, rise wins (normal measurement).
//    STALL: timeout stays 1. On rise: timeout<=0, cnt<=0, go to MEASURE. No valid strobe;
//      the next edge produces the first new period.
//  - cnt never wraps: the timeout bound is reached before 2**CNT_W.
//  - Minimum measurable period is 2 cycles. Input frequencies above clk/2 after
//    synchronisation are undefined.
//  - Latency: period_valid rises 1 cycle after the internal rise pulse, i.e. a fixed
//    SYNC_STAGES+2 cycles after the sig_in edge. period and period_valid update together.
//  - set asserted mid-operation: all outputs and state return to reset values on the next
//    clock edge. Any partial measurement is discarded.
//
// CONFIGURATION
//  DUTY_MEAS_EN defined:
//    - Adds output high_time [CNT_W-1:0] (reset 0).
//    - An internal counter counts cycles with sync_out==1 during MEASURE and clears on rise.
//    - high_time is latched together with period, on the same period_valid cycle.
//  DUTY_MEAS_EN undefined:
//    - The high_time port and its counter do not exist; all other behaviour is identical.
//
// STRUCTURE
//  - Package period_meter_pkg:
//    - state enum {IDLE, MEASURE, STALL};
//    - default CNT_W, TIMEOUT and SYNC_STAGES constants;
//    - localparam EDGE_CNT_W=16.
//  - Sub-module sync_edge_detect (parameter SYNC_STAGES):
//    - in: clk_50MHz, set, async_in;
//    - out: sync_out, rise (reset rules as above).
//  - Top level: FSM, cnt, output registers, optional duty counter.
//
// TESTING
//  1. sig_in square wave, period 10 clks, from reset -> first edge gives no strobe;
//     each later edge gives period=10 and edge_cnt 1,2,3...
//  2. sig_in high at set release, then low, then high after 7 clks -> no measurement
//     from the release; the first valid period comes only after two real rising edges.
//  3. TIMEOUT=100, single edge then none -> timeout=1 at cycle 100 after the edge,
//     period unchanged; next edge clears timeout with no strobe.
//  4. Period exactly TIMEOUT (rise coincides with cnt==TIMEOUT-1) -> period=100,
//     period_valid=1, timeout stays 0.
//  5. set pulsed mid-MEASURE -> outputs zero next cycle, state IDLE; the next edge
//     arms and gives no strobe.
//  6. DUTY_MEAS_EN, 3 clks high / 7 clks low -> period=10, high_time=3 on each strobe.

Source files
------------

// File: rtl/period_meter_pkg.sv
// ----------------------------------------------------------------------------
// period_meter_pkg
// Shared types and default constants for the period meter.
//   state_t          : measurement FSM states (IDLE, MEASURE, STALL)
//   DEF_CNT_W        : default width of the period counter / period output
//   DEF_TIMEOUT      : default stall bound in clk cycles (3 s at 50 MHz)
//   DEF_SYNC_STAGES  : default synchroniser depth (must be >= 2)
//   EDGE_CNT_W       : width of the wrapping completed-measurement counter
// Optional feature macro used by the other files: DUTY_MEAS_EN
// ----------------------------------------------------------------------------
package period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALL   = 2'd2
    } state_t;

    localparam int DEF_CNT_W       = 32;
    localparam int DEF_TIMEOUT     = 150000000;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int EDGE_CNT_W      = 16;

endpackage

// File: rtl/period_meter_if.sv
// ----------------------------------------------------------------------------
// period_meter_if
// Bundles the measured input and the measurement results.
//   sig_in        : asynchronous signal being measured
//   period        : last measured period in clk cycles (CNT_W bits)
//   period_valid  : one-cycle strobe when period updates
//   timeout       : level, no rising edge for TIMEOUT cycles
//   edge_cnt      : completed measurements, wraps at 2**EDGE_CNT_W
//   high_time     : high cycles of the last period (only with DUTY_MEAS_EN)
// Modports:
//   master : the meter side (consumes sig_in, drives the results)
//   slave  : the user side (drives sig_in, consumes the results)
// ----------------------------------------------------------------------------
interface period_meter_if
    import period_meter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic                  sig_in;
    logic [CNT_W-1:0]      period;
    logic                  period_valid;
    logic                  timeout;
    logic [EDGE_CNT_W-1:0] edge_cnt;
`ifdef DUTY_MEAS_EN
    logic [CNT_W-1:0]      high_time;

    modport master (
        input  sig_in,
        output period, period_valid, timeout, edge_cnt, high_time
    );
    modport slave (
        output sig_in,
        input  period, period_valid, timeout, edge_cnt, high_time
    );
`else
    modport master (
        input  sig_in,
        output period, period_valid, timeout, edge_cnt
    );
    modport slave (
        output sig_in,
        input  period, period_valid, timeout, edge_cnt
    );
`endif

endinterface

// File: rtl/period_meter_sync_edge_detect.sv
// ----------------------------------------------------------------------------
// sync_edge_detect
// Synchronises an asynchronous input into clk_50MHz and flags its rising edges.
//   clk_50MHz : sole clock
//   set       : synchronous active-high reset
//   async_in  : asynchronous input
//   sync_out  : synchronised level (last synchroniser stage)
//   rise      : registered one-cycle pulse, SYNC_STAGES+1 cycles after
//               async_in rises (sync_out & ~history, one flop later)
// Parameter SYNC_STAGES (>= 2): synchroniser depth.
// ----------------------------------------------------------------------------
module sync_edge_detect
    import period_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk_50MHz,
    input  logic set,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] w_sync_next;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_hist;
    logic                   r_rise;

    // Stage 0 samples the pin, every later stage samples its predecessor.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign w_sync_next[gi] = async_in;
            end else begin : g_rest
                assign w_sync_next[gi] = r_sync[gi-1];
            end
        end
    endgenerate

    // The synchroniser is cleared by reset, so right after release its output
    // does not yet reflect the pin. History is held at 1 until a real sample
    // has reached the last stage (r_fill fully set); an input that was already
    // high at release therefore never looks like a rising edge.
    always_ff @(posedge clk_50MHz) begin
        if (set) begin
            r_sync <= '0;
            r_fill <= '0;
            r_hist <= 1'b1;
            r_rise <= 1'b0;
        end else begin
            r_sync <= w_sync_next;
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_hist <= r_fill[SYNC_STAGES-1] ? r_sync[SYNC_STAGES-1] : 1'b1;
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_hist;
        end
    end

    assign sync_out = r_sync[SYNC_STAGES-1];
    assign rise     = r_rise;

endmodule

// File: rtl/period_meter.sv
// ----------------------------------------------------------------------------
// period_meter
// Measures the rising-edge-to-rising-edge period of a slow asynchronous input
// in clk_50MHz cycles.
//   clk_50MHz : sole clock, 50 MHz
//   set       : synchronous active-high reset
//   bus       : period_meter_if.master (sig_in in; period, period_valid,
//               timeout, edge_cnt out; high_time out with DUTY_MEAS_EN)
// Parameters: CNT_W, TIMEOUT (< 2**CNT_W), SYNC_STAGES (>= 2).
// CNT_W must match the CNT_W of the connected interface instance.
// Optional feature: define DUTY_MEAS_EN to add high_time (cycles the
// synchronised input was high during the last measured period).
// period_valid follows the sig_in edge by a fixed SYNC_STAGES+2 cycles.
// ----------------------------------------------------------------------------
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic           clk_50MHz,
    input  logic           set,
    period_meter_if.master bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    logic w_sync_out;
    logic w_rise;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_detect (
        .clk_50MHz (clk_50MHz),
        .set       (set),
        .async_in  (bus.sig_in),
        .sync_out  (w_sync_out),
        .rise      (w_rise)
    );

    state_t                r_state, w_state_next;
    logic [CNT_W-1:0]      r_cnt, w_cnt_next;
    logic [CNT_W-1:0]      r_period, w_period_next;
    logic                  r_period_valid, w_period_valid_next;
    logic                  r_timeout, w_timeout_next;
    logic [EDGE_CNT_W-1:0] r_edge_cnt, w_edge_cnt_next;

    always_ff @(posedge clk_50MHz) begin
        if (set) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_timeout      <= 1'b0;
            r_edge_cnt     <= '0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_period       <= w_period_next;
            r_period_valid <= w_period_valid_next;
            r_timeout      <= w_timeout_next;
            r_edge_cnt     <= w_edge_cnt_next;
        end
    end

    // r_cnt holds the number of cycles since the last rise minus one, so the
    // period reported on a rise is r_cnt + 1. A rise takes priority over the
    // timeout check, which lets a period of exactly TIMEOUT be measured.
    always_comb begin
        w_state_next        = r_state;
        w_cnt_next          = r_cnt;
        w_period_next       = r_period;
        w_period_valid_next = 1'b0;
        w_timeout_next      = r_timeout;
        w_edge_cnt_next     = r_edge_cnt;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_next = MEASURE;
                    w_cnt_next   = '0;
                end
            end
            MEASURE: begin
                if (w_rise) begin
                    w_period_next       = r_cnt + CNT_W'(1);
                    w_period_valid_next = 1'b1;
                    w_edge_cnt_next     = r_edge_cnt + EDGE_CNT_W'(1);
                    w_cnt_next          = '0;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_next   = STALL;
                    w_timeout_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            STALL: begin
                // Re-arm only: the interval spent stalled is not a period.
                if (w_rise) begin
                    w_state_next   = MEASURE;
                    w_timeout_next = 1'b0;
                    w_cnt_next     = '0;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.period       = r_period;
    assign bus.period_valid = r_period_valid;
    assign bus.timeout      = r_timeout;
    assign bus.edge_cnt     = r_edge_cnt;

`ifdef DUTY_MEAS_EN
    logic [CNT_W-1:0] r_high_cnt, w_high_cnt_next;
    logic [CNT_W-1:0] r_high_time, w_high_time_next;

    always_ff @(posedge clk_50MHz) begin
        if (set) begin
            r_high_cnt  <= '0;
            r_high_time <= '0;
        end else begin
            r_high_cnt  <= w_high_cnt_next;
            r_high_time <= w_high_time_next;
        end
    end

    // Like the period, the high count includes the cycle on which the rise is
    // seen, so high_time covers exactly the same window as period.
    always_comb begin
        w_high_cnt_next  = r_high_cnt;
        w_high_time_next = r_high_time;
        if (w_rise) begin
            w_high_cnt_next = '0;
            if (r_state == MEASURE) begin
                w_high_time_next = r_high_cnt + CNT_W'(w_sync_out);
            end
        end else if (r_state == MEASURE) begin
            w_high_cnt_next = r_high_cnt + CNT_W'(w_sync_out);
        end
    end

    assign bus.high_time = r_high_time;
`else
    // The synchronised level is only needed by the duty counter.
    logic w_unused_sync_out;
    assign w_unused_sync_out = w_sync_out;
`endif

endmodule

// File: tb/tb_period_meter.sv
// ----------------------------------------------------------------------------
// tb_period_meter
// Self-checking bench for period_meter (TIMEOUT shortened to 100 cycles).
// Expected strobes are queued when the measured edge is driven and compared
// when period_valid fires. Define DUTY_MEAS_EN to also check high_time.
// ----------------------------------------------------------------------------
module tb_period_meter;
    import period_meter_pkg::*;

    localparam int CNT_W   = 32;
    localparam int TB_TO   = 100;
    localparam int SYNC    = 2;

    logic clk = 1'b0;
    logic set = 1'b1;
    always #10 clk = ~clk;

    period_meter_if #(.CNT_W(CNT_W)) bus ();

    period_meter #(
        .CNT_W       (CNT_W),
        .TIMEOUT     (TB_TO),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk_50MHz (clk),
        .set       (set),
        .bus       (bus)
    );

    typedef struct {
        logic [CNT_W-1:0]      period;
        logic [EDGE_CNT_W-1:0] edge_cnt;
        logic [CNT_W-1:0]      high;
    } exp_t;

    typedef struct {
        int               hi;
        int               lo;
        int               n;
        logic [CNT_W-1:0] exp_period;
    } vec_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_edge  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] h);
        exp_t e;
        n_edge++;
        e.period   = p;
        e.edge_cnt = EDGE_CNT_W'(n_edge);
        e.high     = h;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        set        = 1'b1;
        bus.sig_in = 1'b0;
        tick(2);
        set = 1'b0;
        sb_q.delete();
        n_edge = 0;
        tick(3);
    endtask

    // Square wave: first rise arms the meter, each of the n later rises is
    // a measurement of hi+lo cycles.
    task automatic run_wave(input int hi, input int lo, input int n, input logic [CNT_W-1:0] p);
        for (int k = 0; k <= n; k++) begin
            if (k > 0) push(p, CNT_W'(hi));
            bus.sig_in = 1'b1;
            tick(hi);
            if (k < n) begin
                bus.sig_in = 1'b0;
                tick(lo);
            end
        end
    endtask

    // Scoreboard consumer: one line per strobe.
    always @(negedge clk) begin
        if (bus.period_valid) begin
            $display("[TB] strobe period=%0d edge_cnt=%0d", bus.period, bus.edge_cnt);
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("strobe_period", bus.period, e.period);
                check("strobe_edge_cnt", bus.edge_cnt, e.edge_cnt);
`ifdef DUTY_MEAS_EN
                check("strobe_high_time", bus.high_time, e.high);
`endif
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{hi: 5,  lo: 5,  n: 4, exp_period: 10};
        vecs[1] = '{hi: 1,  lo: 1,  n: 4, exp_period: 2};
        vecs[2] = '{hi: 3,  lo: 7,  n: 3, exp_period: 10};
        vecs[3] = '{hi: 2,  lo: 5,  n: 3, exp_period: 7};
        vecs[4] = '{hi: 50, lo: 49, n: 2, exp_period: 99};
        vecs[5] = '{hi: 1,  lo: 98, n: 2, exp_period: 99};

        // Reset state
        bus.sig_in = 1'b0;
        set        = 1'b1;
        tick(3);
        check("rst_period", bus.period, 0);
        check("rst_valid", bus.period_valid, 0);
        check("rst_timeout", bus.timeout, 0);
        check("rst_edge_cnt", bus.edge_cnt, 0);
`ifdef DUTY_MEAS_EN
        check("rst_high_time", bus.high_time, 0);
`endif

        // Table-driven square waves
        for (int v = 0; v < 6; v++) begin
            do_reset();
            run_wave(vecs[v].hi, vecs[v].lo, vecs[v].n, vecs[v].exp_period);
            tick(8);
            check("vec_drain", sb_q.size(), 0);
            check("vec_timeout", bus.timeout, 0);
            check("vec_edge_cnt", bus.edge_cnt, vecs[v].n);
        end

        // Latency: strobe exactly SYNC+2 cycles after the measured edge
        do_reset();
        bus.sig_in = 1'b1; tick(3);
        bus.sig_in = 1'b0; tick(3);
        push(6, 3);
        bus.sig_in = 1'b1;
        for (int i = 1; i <= SYNC + 3; i++) begin
            tick(1);
            check("latency_valid", bus.period_valid, (i == SYNC + 2) ? 1 : 0);
        end
        tick(4);
        check("latency_drain", sb_q.size(), 0);

        // Input already high at reset release is not an edge
        set        = 1'b1;
        bus.sig_in = 1'b1;
        tick(2);
        set = 1'b0;
        sb_q.delete();
        n_edge = 0;
        tick(10);
        check("hi_release_edge_cnt", bus.edge_cnt, 0);
        bus.sig_in = 1'b0; tick(7);
        bus.sig_in = 1'b1; tick(4);
        bus.sig_in = 1'b0; tick(4);
        push(8, 4);
        bus.sig_in = 1'b1; tick(8);
        check("hi_release_drain", sb_q.size(), 0);
        check("hi_release_edge_cnt2", bus.edge_cnt, 1);

        // Timeout after a single edge, then recovery without a strobe
        do_reset();
        run_wave(5, 5, 1, 10);
        tick(TB_TO + SYNC + 1 - 5);
        check("to_before", bus.timeout, 0);
        tick(1);
        check("to_set", bus.timeout, 1);
        check("to_period_kept", bus.period, 10);
        check("to_edge_cnt_kept", bus.edge_cnt, 1);
        bus.sig_in = 1'b0; tick(3);
        bus.sig_in = 1'b1; tick(8);
        check("to_cleared", bus.timeout, 0);
        bus.sig_in = 1'b0; tick(5);
        push(13, 8);
        bus.sig_in = 1'b1; tick(8);
        check("to_drain", sb_q.size(), 0);
        check("to_edge_cnt", bus.edge_cnt, 2);

        // Period exactly TIMEOUT: rise wins; then TIMEOUT+1 stalls
        do_reset();
        bus.sig_in = 1'b1; tick(50);
        bus.sig_in = 1'b0; tick(50);
        push(TB_TO, 50);
        bus.sig_in = 1'b1; tick(SYNC + 2);
        check("exact_valid", bus.period_valid, 1);
        check("exact_timeout", bus.timeout, 0);
        tick(46);
        bus.sig_in = 1'b0; tick(51);
        bus.sig_in = 1'b1; tick(3);
        check("over_timeout_set", bus.timeout, 1);
        tick(1);
        check("over_timeout_clr", bus.timeout, 0);
        tick(8);
        check("over_edge_cnt", bus.edge_cnt, 1);
        bus.sig_in = 1'b0; tick(4);
        push(16, 12);
        bus.sig_in = 1'b1; tick(8);
        check("over_drain", sb_q.size(), 0);

        // set pulsed mid-measurement
        do_reset();
        run_wave(5, 5, 1, 10);
        bus.sig_in = 1'b0; tick(3);
        set = 1'b1; tick(1);
        check("midrst_period", bus.period, 0);
        check("midrst_edge_cnt", bus.edge_cnt, 0);
        check("midrst_valid", bus.period_valid, 0);
        check("midrst_timeout", bus.timeout, 0);
        check("midrst_drain", sb_q.size(), 0);
        set = 1'b0;
        n_edge = 0;
        tick(3);
        bus.sig_in = 1'b1; tick(5);
        bus.sig_in = 1'b0; tick(5);
        push(10, 5);
        bus.sig_in = 1'b1; tick(8);
        check("midrst_rearm_drain", sb_q.size(), 0);
        check("midrst_rearm_edge_cnt", bus.edge_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
